// File: rtl/interp_pkg.sv
// Shared types and sizing helpers for the polyphase interpolator.
// The state encoding and the coefficient index math live here so every file sizes things the same way.
package interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // One guard bit above the full-precision sum of ntaps products.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps) + 1;
  endfunction

  function automatic int phase_width(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

  // Bit offset of phase p, tap k inside the packed coefficient vector.
  function automatic int coeff_at(input int p, input int k, input int ntaps, input int cw);
    return (p * ntaps + k) * cw;
  endfunction

endpackage

// File: rtl/interp_round_sat.sv
// Round-half-up, arithmetic right shift and saturation of an accumulator to OUT_WIDTH.
// Purely combinational; ovf_o flags that the saturated value differs from the rounded one.
module interp_round_sat #(
  parameter int ACC_W      = 35,
  parameter int FRAC_SHIFT = 15,
  parameter int OUT_WIDTH  = 16
) (
  input  logic signed [ACC_W-1:0]     acc_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        ovf_o
);

  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_SHIFT - 1);

  logic signed [ACC_W-1:0] sum_w;
  logic signed [ACC_W-1:0] shr_w;

  assign sum_w = acc_i + $signed(HALF);
  assign shr_w = sum_w >>> FRAC_SHIFT;

  generate
    if (OUT_WIDTH < ACC_W) begin : g_sat
      localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      logic [ACC_W-OUT_WIDTH:0] hi_w;

      // The value fits only if every bit from the output sign bit upward matches.
      assign hi_w   = shr_w[ACC_W-1:OUT_WIDTH-1];
      assign ovf_o  = ~((&hi_w) | (~|hi_w));
      assign data_o = ovf_o ? (shr_w[ACC_W-1] ? SAT_MIN : SAT_MAX) : shr_w[OUT_WIDTH-1:0];
    end else begin : g_wide
      assign ovf_o  = 1'b0;
      assign data_o = OUT_WIDTH'(shr_w);
    end
  endgenerate

endmodule

// File: rtl/polyphase_interpolator.sv
// L-phase polyphase FIR interpolator: one input beat in, L rounded/saturated beats out.
// Valid/ready: a beat transfers on any edge where valid and ready are both high; a source holding valid keeps its data stable.
module polyphase_interpolator
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int L           = 2,
  parameter int N_TAPS      = 4,
  parameter int FRAC_SHIFT  = 15,
  parameter int OUT_WIDTH   = 16,
  parameter logic [L*N_TAPS*COEFF_WIDTH-1:0] COEFFS =
    128'h0000_0000_4000_4000_0000_0000_0000_7FFF
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         bypass,
  input  logic                         ovf_clr,
  input  logic [DATA_WIDTH-1:0]        src_data_in,
  input  logic                         src_valid_in,
  output logic                         src_ready_out,
  output logic [OUT_WIDTH-1:0]         dst_data_out,
  output logic                         dst_valid_out,
  input  logic                         dst_ready_in,
  output logic [phase_width(L)-1:0]    dst_phase_out,
  output logic                         ovf_sticky_out,
  output state_t                       fsm_state_out
);

  localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
  localparam int BYP_W = DATA_WIDTH + FRAC_SHIFT + 1;
  localparam int PW    = phase_width(L);
  localparam logic [PW-1:0] LAST_PHASE = PW'(L - 1);

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  delay_q [N_TAPS];
  logic signed [OUT_WIDTH-1:0]   phase_q [L];
  logic [PW-1:0]                 cnt_q, cnt_d;
  logic                          byp_q;
  logic                          ovf_q, ovf_d;

  logic                          accept;
  logic                          handshake;
  logic                          last_beat;
  logic signed [ACC_W-1:0]       prod_w [L][N_TAPS];
  logic signed [ACC_W-1:0]       acc_w [L];
  logic signed [OUT_WIDTH-1:0]   rs_data [L];
  logic [L-1:0]                  rs_ovf;
  logic signed [BYP_W-1:0]       byp_acc;
  logic signed [OUT_WIDTH-1:0]   byp_data;
  logic                          byp_ovf;

  genvar gp, gk;
  generate
    for (gp = 0; gp < L; gp++) begin : g_phase
      for (gk = 0; gk < N_TAPS; gk++) begin : g_tap
        localparam int OFF = coeff_at(gp, gk, N_TAPS, COEFF_WIDTH);
        assign prod_w[gp][gk] = ACC_W'($signed(COEFFS[OFF +: COEFF_WIDTH])) * ACC_W'(delay_q[gk]);
      end

      interp_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
      ) u_rs (
        .acc_i (acc_w[gp]),
        .data_o(rs_data[gp]),
        .ovf_o (rs_ovf[gp])
      );
    end
  endgenerate

  always_comb begin
    for (int p = 0; p < L; p++) begin
      acc_w[p] = '0;
      for (int k = 0; k < N_TAPS; k++) begin
        acc_w[p] = acc_w[p] + prod_w[p][k];
      end
    end
  end

  // Pre-shifting the sample lets the shared rounder act as a plain sign-extend/saturate.
  assign byp_acc = {delay_q[0][DATA_WIDTH-1], delay_q[0], {FRAC_SHIFT{1'b0}}};

  interp_round_sat #(
    .ACC_W     (BYP_W),
    .FRAC_SHIFT(FRAC_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_rs_byp (
    .acc_i (byp_acc),
    .data_o(byp_data),
    .ovf_o (byp_ovf)
  );

  assign handshake     = (state_q == ST_EMIT) & dst_ready_in;
  assign last_beat     = byp_q | (cnt_q == LAST_PHASE);
  assign src_ready_out = (state_q == ST_IDLE) | ((state_q == ST_EMIT) & last_beat & dst_ready_in);
  assign accept        = src_valid_in & src_ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (handshake) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = src_valid_in ? ST_COMPUTE : ST_IDLE;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over a same-cycle saturation.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if ((state_q == ST_COMPUTE) && (byp_q ? byp_ovf : (|rs_ovf))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byp_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) delay_q[k] <= '0;
      for (int p = 0; p < L; p++) phase_q[p] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        delay_q[0] <= src_data_in;
        for (int k = 1; k < N_TAPS; k++) delay_q[k] <= delay_q[k-1];
        byp_q <= bypass;
      end
      if (state_q == ST_COMPUTE) begin
        if (byp_q) begin
          phase_q[0] <= byp_data;
        end else begin
          for (int p = 0; p < L; p++) phase_q[p] <= rs_data[p];
        end
      end
    end
  end

  assign dst_valid_out  = (state_q == ST_EMIT);
  assign dst_data_out   = phase_q[cnt_q];
  assign dst_phase_out  = cnt_q;
  assign ovf_sticky_out = ovf_q;
  assign fsm_state_out  = state_q;

endmodule

// File: tb/tb_polyphase_interpolator.sv
// Directed bench for polyphase_interpolator: default, saturating and L=4 builds share one stimulus set.
// Inputs change just after the falling edge; outputs are read 1 time unit later, well before the rising edge.
module tb_polyphase_interpolator;
  import interp_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        bypass;
  logic        ovf_clr;
  logic [15:0] src_data;
  logic        src_valid;
  logic        dst_ready;

  logic        rdy0, val0, ovf0;
  logic [15:0] dat0;
  logic [0:0]  ph0;
  state_t      st0;
  logic        rdy1, val1, ovf1;
  logic [15:0] dat1;
  logic [0:0]  ph1;
  state_t      st1;
  logic        rdy2, val2, ovf2;
  logic [15:0] dat2;
  logic [1:0]  ph2;
  state_t      st2;

  int          sel;
  logic        obs_ready, obs_valid, obs_ovf;
  logic [15:0] obs_data;
  logic [1:0]  obs_phase;
  state_t      obs_state;

  int total;
  int bad;

  polyphase_interpolator u_dut (
    .clk(clk), .arst_n(arst_n), .bypass(bypass), .ovf_clr(ovf_clr),
    .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(rdy0),
    .dst_data_out(dat0), .dst_valid_out(val0), .dst_ready_in(dst_ready),
    .dst_phase_out(ph0), .ovf_sticky_out(ovf0), .fsm_state_out(st0)
  );

  polyphase_interpolator #(
    .COEFFS(128'h0000_0000_4000_4000_0000_0000_7FFF_7FFF)
  ) u_sat (
    .clk(clk), .arst_n(arst_n), .bypass(bypass), .ovf_clr(ovf_clr),
    .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(rdy1),
    .dst_data_out(dat1), .dst_valid_out(val1), .dst_ready_in(dst_ready),
    .dst_phase_out(ph1), .ovf_sticky_out(ovf1), .fsm_state_out(st1)
  );

  polyphase_interpolator #(
    .L(4), .N_TAPS(1),
    .COEFFS(64'h7FFF_7FFF_7FFF_7FFF)
  ) u_l4 (
    .clk(clk), .arst_n(arst_n), .bypass(bypass), .ovf_clr(ovf_clr),
    .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(rdy2),
    .dst_data_out(dat2), .dst_valid_out(val2), .dst_ready_in(dst_ready),
    .dst_phase_out(ph2), .ovf_sticky_out(ovf2), .fsm_state_out(st2)
  );

  always_comb begin
    obs_ready = rdy0; obs_valid = val0; obs_ovf = ovf0;
    obs_data = dat0; obs_phase = {1'b0, ph0}; obs_state = st0;
    case (sel)
      1: begin
        obs_ready = rdy1; obs_valid = val1; obs_ovf = ovf1;
        obs_data = dat1; obs_phase = {1'b0, ph1}; obs_state = st1;
      end
      2: begin
        obs_ready = rdy2; obs_valid = val2; obs_ovf = ovf2;
        obs_data = dat2; obs_phase = ph2; obs_state = st2;
      end
      default: ;
    endcase
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    bypass    = 1'b0;
    ovf_clr   = 1'b0;
    dst_ready = 1'b1;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
  endtask

  // Driver: presents one sample, waits (bounded) for ready, returns in the COMPUTE cycle.
  task automatic send(input logic [15:0] d, input logic b);
    src_data  = d;
    bypass    = b;
    src_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !obs_ready; i++) begin
      tick();
      #1;
    end
    total++;
    if (obs_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready_timeout got=%b exp=1", obs_ready);
    end
    tick();
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    #1;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", obs_valid); end
    total++; if (obs_data !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h exp=0000", obs_data); end
    total++; if (obs_phase !== 2'd0) begin bad++; $display("FAIL rst_phase got=%0d exp=0", obs_phase); end
    total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", obs_ovf); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", obs_ready); end
    total++; if (obs_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", obs_state, ST_IDLE); end
  endtask

  task automatic test_basic();
    sel = 0;
    tick();
    send(16'd1000, 1'b0);
    #1;
    total++; if (obs_valid !== 1'b0 || obs_ready !== 1'b0) begin bad++; $display("FAIL basic_compute valid=%b ready=%b exp=0/0", obs_valid, obs_ready); end
    total++; if (obs_state !== ST_COMPUTE) begin bad++; $display("FAIL basic_state got=%0d exp=%0d", obs_state, ST_COMPUTE); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'd1000) begin bad++; $display("FAIL basic_b0 valid=%b phase=%0d data=%0d exp=1/0/1000", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    src_data  = 16'd2000;
    src_valid = 1'b1;
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd1 || obs_data !== 16'd500) begin bad++; $display("FAIL basic_b1 valid=%b phase=%0d data=%0d exp=1/1/500", obs_valid, obs_phase, $signed(obs_data)); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL basic_overlap_ready got=%b exp=1", obs_ready); end
    tick();
    src_valid = 1'b0;
    #1;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL basic_gap got=%b exp=0", obs_valid); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'd2000) begin bad++; $display("FAIL basic_b2 valid=%b phase=%0d data=%0d exp=1/0/2000", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd1 || obs_data !== 16'd1500) begin bad++; $display("FAIL basic_b3 valid=%b phase=%0d data=%0d exp=1/1/1500", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_ovf !== 1'b0) begin bad++; $display("FAIL basic_end valid=%b ready=%b ovf=%b exp=0/1/0", obs_valid, obs_ready, obs_ovf); end
  endtask

  task automatic test_backpressure();
    sel = 0;
    tick();
    send(16'd1000, 1'b0);
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_data !== 16'd1000) begin bad++; $display("FAIL bp_b0 valid=%b data=%0d exp=1/1000", obs_valid, $signed(obs_data)); end
    tick();
    dst_ready = 1'b0;
    src_data  = 16'd3000;
    src_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs_valid !== 1'b1 || obs_data !== 16'd1500 || obs_phase !== 2'd1 || obs_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall%0d valid=%b data=%0d phase=%0d ready=%b exp=1/1500/1/0", i, obs_valid, $signed(obs_data), obs_phase, obs_ready);
      end
      tick();
      #1;
    end
    dst_ready = 1'b1;
    #1;
    total++; if (obs_ready !== 1'b1 || obs_data !== 16'd1500) begin bad++; $display("FAIL bp_release ready=%b data=%0d exp=1/1500", obs_ready, $signed(obs_data)); end
    tick();
    src_valid = 1'b0;
    #1;
    total++; if (obs_valid !== 1'b0 || obs_state !== ST_COMPUTE) begin bad++; $display("FAIL bp_compute valid=%b state=%0d exp=0/%0d", obs_valid, obs_state, ST_COMPUTE); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'd3000) begin bad++; $display("FAIL bp_next_b0 valid=%b phase=%0d data=%0d exp=1/0/3000", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd1 || obs_data !== 16'd2000) begin bad++; $display("FAIL bp_next_b1 valid=%b phase=%0d data=%0d exp=1/1/2000", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
  endtask

  task automatic test_saturation();
    sel = 1;
    do_reset();
    send(16'd32767, 1'b0);
    tick();
    #1;
    total++; if (obs_data !== 16'd32766 || obs_ovf !== 1'b0) begin bad++; $display("FAIL sat_first data=%0d ovf=%b exp=32766/0", $signed(obs_data), obs_ovf); end
    tick();
    #1;
    total++; if (obs_data !== 16'd16384) begin bad++; $display("FAIL sat_first_p1 got=%0d exp=16384", $signed(obs_data)); end
    tick();
    send(16'd32767, 1'b0);
    tick();
    #1;
    total++; if (obs_data !== 16'h7FFF || obs_ovf !== 1'b1) begin bad++; $display("FAIL sat_pos data=%0d ovf=%b exp=32767/1", $signed(obs_data), obs_ovf); end
    tick();
    #1;
    total++; if (obs_data !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_p1 got=%0d exp=32767", $signed(obs_data)); end
    tick();
    send(16'h8000, 1'b0);
    tick();
    #1;
    total++; if (obs_data !== 16'hFFFF) begin bad++; $display("FAIL sat_mix got=%0d exp=-1", $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_data !== 16'h0000) begin bad++; $display("FAIL sat_mix_p1 got=%0d exp=0", $signed(obs_data)); end
    tick();
    send(16'h8000, 1'b0);
    tick();
    #1;
    total++; if (obs_data !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%0d exp=-32768", $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_data !== 16'h8000) begin bad++; $display("FAIL sat_neg_p1 got=%0d exp=-32768", $signed(obs_data)); end
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", obs_ovf); end
    send(16'h8000, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    total++; if (obs_ovf !== 1'b0 || obs_data !== 16'h8000) begin bad++; $display("FAIL ovf_set_clr ovf=%b data=%0d exp=0/-32768", obs_ovf, $signed(obs_data)); end
    tick();
    tick();
  endtask

  task automatic test_bypass();
    sel = 0;
    do_reset();
    send(16'(-1234), 1'b1);
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'(-1234)) begin bad++; $display("FAIL byp_beat valid=%b phase=%0d data=%0d exp=1/0/-1234", obs_valid, obs_phase, $signed(obs_data)); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL byp_last_ready got=%b exp=1", obs_ready); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL byp_single got=%b exp=0", obs_valid); end
    send(16'd500, 1'b0);
    bypass = 1'b1;
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'd500) begin bad++; $display("FAIL byp_toggle_b0 valid=%b phase=%0d data=%0d exp=1/0/500", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd1 || obs_data !== 16'(-367)) begin bad++; $display("FAIL byp_toggle_b1 valid=%b phase=%0d data=%0d exp=1/1/-367", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL byp_toggle_end got=%b exp=0", obs_valid); end
    bypass = 1'b0;
  endtask

  task automatic test_l4();
    sel = 2;
    do_reset();
    send(16'd100, 1'b0);
    tick();
    for (int ph = 0; ph < 4; ph++) begin
      #1;
      total++;
      if (obs_valid !== 1'b1 || obs_phase !== 2'(ph) || obs_data !== 16'd100 || obs_ready !== (ph == 3)) begin
        bad++;
        $display("FAIL l4_beat%0d valid=%b phase=%0d data=%0d ready=%b exp=1/%0d/100/%0d", ph, obs_valid, obs_phase, $signed(obs_data), obs_ready, ph, (ph == 3));
      end
      tick();
    end
    #1;
    total++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin bad++; $display("FAIL l4_end valid=%b ready=%b exp=0/1", obs_valid, obs_ready); end
  endtask

  task automatic test_reset_mid_emit();
    sel = 1;
    do_reset();
    send(16'd32767, 1'b0);
    repeat (3) tick();
    send(16'd32767, 1'b0);
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_ovf !== 1'b1) begin bad++; $display("FAIL rme_pre valid=%b ovf=%b exp=1/1", obs_valid, obs_ovf); end
    arst_n = 1'b0;
    #1;
    total++; if (obs_valid !== 1'b0 || obs_ovf !== 1'b0 || obs_data !== 16'h0000 || obs_phase !== 2'd0) begin bad++; $display("FAIL rme_async valid=%b ovf=%b data=%0d phase=%0d exp=0/0/0/0", obs_valid, obs_ovf, $signed(obs_data), obs_phase); end
    tick();
    arst_n = 1'b1;
    tick();
    send(16'd1000, 1'b0);
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd0 || obs_data !== 16'd1000) begin bad++; $display("FAIL rme_b0 valid=%b phase=%0d data=%0d exp=1/0/1000", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b1 || obs_phase !== 2'd1 || obs_data !== 16'd500) begin bad++; $display("FAIL rme_b1 valid=%b phase=%0d data=%0d exp=1/1/500", obs_valid, obs_phase, $signed(obs_data)); end
    tick();
    #1;
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rme_end got=%b exp=0", obs_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_bypass();
    test_l4();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/polyphase_interpolator.md
Name: polyphase_interpolator

Overview:
- Parametrised L-phase polyphase FIR interpolator. It generalises the fixed two-branch interpolator to any interpolation factor L and any taps-per-phase count.
- Accepts one sample per valid/ready beat and emits L output samples (phase 0..L-1) with round-half-up and saturation to a configurable output width.
- Provides a sticky overflow flag and a registered bypass mode.
- Sits in the DSP datapath between the sample source and rate-consuming downstream blocks.

Parameters:
- DATA_WIDTH, 16, signed input sample width.
- COEFF_WIDTH, 16, signed coefficient width.
- L, 2, interpolation factor / phase count (2..8).
- N_TAPS, 4, taps per phase (1..16).
- FRAC_SHIFT, 15, right shift applied to the accumulator before saturation (>=1).
- OUT_WIDTH, 16, signed output width.
- COEFFS, 128'h0000_0000_4000_4000_0000_0000_0000_7FFF, packed L*N_TAPS*COEFF_WIDTH. Phase p, tap k is at bit offset (p*N_TAPS+k)*COEFF_WIDTH.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- bypass  in  1  sampled at input accept; 1 = pass-through.
- ovf_clr  in  1  clears the sticky overflow flag.
- src_data_in  in  DATA_WIDTH  signed input sample.
- src_valid_in  in  1  input valid.
- src_ready_out  out  1  input ready.
- dst_data_out  out  OUT_WIDTH  signed output sample.
- dst_valid_out  out  1  output valid.
- dst_ready_in  in  1  output ready.
- dst_phase_out  out  max(1,$clog2(L))  phase index of the current output.
- ovf_sticky_out  out  1  set when any produced output saturated.

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is asynchronous, active-low.
- Reset values: FSM=IDLE, delay line=0, phase registers=0, phase counter=0, bypass latch=0, ovf_sticky_out=0, dst_valid_out=0, dst_data_out=0, dst_phase_out=0. src_ready_out=1 after reset release.
- FSM states:
  - IDLE: src_ready_out=1. On accept (src_valid_in & src_ready_out), go to COMPUTE.
  - COMPUTE: 1 cycle, src_ready_out=0. Go to EMIT.
  - EMIT: dst_valid_out=1.
- Accept action: shift src_data_in into the N_TAPS delay line (tap0 = newest, x[n-k] at tap k). Latch bypass.
- COMPUTE action: y_p = sum_k COEFFS[p][k]*x[n-k], for all p in parallel.
  - Accumulator width = DATA_WIDTH+COEFF_WIDTH+$clog2(N_TAPS)+1.
  - Add 1<<(FRAC_SHIFT-1), arithmetic shift right by FRAC_SHIFT.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the result into phase register p.
  - Any saturated phase sets ovf_sticky_out at the end of this cycle.
- EMIT action:
  - dst_data_out = phase register [phase counter]; dst_phase_out = phase counter.
  - Each handshake (dst_valid_out & dst_ready_in) increments the counter.
  - Handshake on the last phase (L-1, or phase 0 when in bypass) resets the counter to 0.
  - If src_valid_in is also high on that last handshake, go to COMPUTE; otherwise go to IDLE.
- Overlap ready: src_ready_out = IDLE | (EMIT & last phase & dst_ready_in). This is a combinational path from dst_ready_in and is the only such path. Peak throughput is one input per L+1 cycles.
- Latency: accept at edge t gives phase 0 valid in cycle t+2.
- Backpressure: dst_data_out, dst_phase_out and dst_valid_out hold stable while dst_valid_out & ~dst_ready_in. Stall duration is unbounded.
- Bypass (latched at accept):
  - Phase register 0 = src_data_in sign-extended or saturated to OUT_WIDTH. Saturation sets ovf_sticky_out.
  - One output beat per input, dst_phase_out=0.
  - The delay line still shifts, so history stays coherent when bypass is released.
- Simultaneous set and clear: ovf_clr has priority over a same-cycle set.
- Mode changes: changes to bypass mid-EMIT have no effect until the next accept.
- Reset mid-EMIT: outputs drop to reset values immediately. The pending beats are discarded.

Decomposition:
- Package interp_pkg holds:
  - FSM state encoding (IDLE, COMPUTE, EMIT).
  - Function acc_width(dw, cw, ntaps).
  - Function coeff_at(p, k) for indexing the packed coefficients.
- Sub-module interp_round_sat (combinational): accumulator → rounded and saturated OUT_WIDTH value plus an overflow bit. Instantiated L+1 times (L phases plus bypass).

Test Plan:
1. Defaults, dst_ready_in=1: inputs 1000 then 2000 give outputs (phase,data) (0,1000), (1,500), (0,2000), (1,1500). First output is 2 cycles after accept; ovf_sticky_out stays 0.
2. Backpressure: hold dst_ready_in=0 for 5 cycles during phase 1 → dst_data_out=1500 and dst_phase_out=1 stable, src_ready_out=0. Release → handshake completes. A concurrent src_valid_in is accepted on that beat and the next sample's phase 0 appears 2 cycles later.
3. Saturation, COEFFS phase0 tap0=tap1=16'h7FFF: inputs 32767, 32767 → second phase 0 output = 32767 and ovf_sticky_out=1. Inputs -32768, -32768 → -32768. Pulse ovf_clr → flag 0. Same-cycle set and clear → flag 0.
4. Bypass=1: input -1234 → single beat -1234 with dst_phase_out=0. Toggle bypass during EMIT → the current sample's beat count is unchanged.
5. L=4, N_TAPS=1, COEFFS all 16'h7FFF: input 100 → four beats of 100 with phases 0,1,2,3, then src_ready_out returns to 1.
6. Assert arst_n low during EMIT → dst_valid_out=0, ovf_sticky_out=0 immediately. After release, input 1000 → (0,1000), (1,500), since the delay line was cleared.
